// File: rtl/mem_access_ctrl_if.sv
// Bundles the request, response and memory-bus signals of mem_access_ctrl.
// The slave modport is the controller; master is the requester/bus side.
interface mem_access_ctrl_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_ren;
    logic        d_wen;
    logic [31:0] d_addr;
    logic [1:0]  d_size;
    logic [31:0] d_wdata;
    logic        bus_busy;
    logic [31:0] bus_rdata;
    logic        bus_ren;
    logic        bus_wen;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic [31:0] memload;
    logic        d_done;
    logic        misalign;
    logic        bus_err;
    logic        stall;

    modport slave (
        input  i_req, i_addr, d_ren, d_wen, d_addr, d_size, d_wdata, bus_busy, bus_rdata,
        output bus_ren, bus_wen, bus_addr, bus_sel, bus_wdata, instr_out, instr_valid,
        output memload, d_done, misalign, bus_err, stall
    );

    modport master (
        output i_req, i_addr, d_ren, d_wen, d_addr, d_size, d_wdata, bus_busy, bus_rdata,
        input  bus_ren, bus_wen, bus_addr, bus_sel, bus_wdata, instr_out, instr_valid,
        input  memload, d_done, misalign, bus_err, stall
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Arbitrates the shared memory bus between instruction fetch and data load/store.
// Define MEM_ACCESS_TIMEOUT_EN to abort accesses after TIMEOUT_CYC busy cycles.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              nRst,
    mem_access_ctrl_if.slave  bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]  state;
    logic        busRen;
    logic        busWen;
    logic [31:0] busAddr;
    logic [3:0]  busSel;
    logic [31:0] busWdata;
    logic [31:0] instrOut;
    logic        instrValid;
    logic [31:0] memload;
    logic        dDone;
    logic        misalign;
    logic        busErr;
    logic [1:0]  offset;

    logic        anyData;
    logic        misaligned;
    logic [3:0]  dataSel;
    logic        timeoutHit;

    assign anyData = bus.d_ren | bus.d_wen;

    always_comb begin
        misaligned = 1'b0;
        dataSel    = 4'b1111;
        unique case (bus.d_size)
            2'b00: dataSel = 4'b0001 << bus.d_addr[1:0];
            2'b01: begin
                dataSel    = bus.d_addr[1] ? 4'b1100 : 4'b0011;
                misaligned = bus.d_addr[0];
            end
            default: misaligned = (bus.d_addr[1:0] != 2'b00);
        endcase
    end

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CntW-1:0] busyCnt;

    // Abort on the busy cycle that completes TIMEOUT_CYC consecutive busy cycles.
    assign timeoutHit = bus.bus_busy && (busyCnt == CntW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            busyCnt <= '0;
        end else if (state == IDLE) begin
            busyCnt <= '0;
        end else if ((state == FETCH || state == DATA) && bus.bus_busy && !timeoutHit) begin
            busyCnt <= busyCnt + 1'b1;
        end
    end
`else
    assign timeoutHit = 1'b0;
`endif

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state      <= IDLE;
            busRen     <= 1'b0;
            busWen     <= 1'b0;
            busAddr    <= '0;
            busSel     <= '0;
            busWdata   <= '0;
            instrOut   <= '0;
            instrValid <= 1'b0;
            memload    <= '0;
            dDone      <= 1'b0;
            misalign   <= 1'b0;
            busErr     <= 1'b0;
            offset     <= '0;
        end else begin
            instrValid <= 1'b0;
            dDone      <= 1'b0;
            misalign   <= 1'b0;
            busErr     <= 1'b0;
            case (state)
                IDLE: begin
                    // Data first: it belongs to an older instruction than the fetch.
                    if (anyData && misaligned) begin
                        state    <= DONE;
                        dDone    <= 1'b1;
                        misalign <= 1'b1;
                    end else if (anyData) begin
                        state    <= DATA;
                        busRen   <= ~bus.d_wen;
                        busWen   <= bus.d_wen;
                        busAddr  <= bus.d_addr & ~32'h3;
                        busSel   <= dataSel;
                        busWdata <= bus.d_wdata << {bus.d_addr[1:0], 3'b000};
                        offset   <= bus.d_addr[1:0];
                    end else if (bus.i_req) begin
                        state   <= FETCH;
                        busRen  <= 1'b1;
                        busAddr <= bus.i_addr & ~32'h3;
                        busSel  <= 4'b1111;
                    end
                end
                FETCH, DATA: begin
                    if (!bus.bus_busy || timeoutHit) begin
                        state  <= DONE;
                        busRen <= 1'b0;
                        busWen <= 1'b0;
                        busErr <= timeoutHit;
                        if (state == FETCH) begin
                            instrValid <= 1'b1;
                            if (!timeoutHit) instrOut <= bus.bus_rdata;
                        end else begin
                            dDone <= 1'b1;
                            if (!timeoutHit && !busWen) begin
                                memload <= bus.bus_rdata >> {offset, 3'b000};
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.bus_ren     = busRen;
    assign bus.bus_wen     = busWen;
    assign bus.bus_addr    = busAddr;
    assign bus.bus_sel     = busSel;
    assign bus.bus_wdata   = busWdata;
    assign bus.instr_out   = instrOut;
    assign bus.instr_valid = instrValid;
    assign bus.memload     = memload;
    assign bus.d_done      = dDone;
    assign bus.misalign    = misalign;
    assign bus.bus_err     = busErr;
    assign bus.stall       = (bus.i_req | anyData) & ~(instrValid | dDone);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a vector table of single transactions
// plus hand-written sequences for arbitration, timeout/indefinite wait and reset.
module tb_mem_access_ctrl;

    logic clk;
    logic nRst;
    int   nCmp;
    int   nFail;
    logic [31:0] modelInstr;
    logic [31:0] modelLoad;

    mem_access_ctrl_if mif ();

    mem_access_ctrl #(.TIMEOUT_CYC(64)) dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fetch;
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          busy;
        logic        mis;
        logic [31:0] eAddr;
        logic [3:0]  eSel;
        logic [31:0] eWdata;
        logic [31:0] eData;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idleInputs();
        mif.i_req    = 1'b0;
        mif.d_ren    = 1'b0;
        mif.d_wen    = 1'b0;
        mif.bus_busy = 1'b0;
    endtask

    task automatic runVec(input int idx, input vec_t v);
        int   cyc;
        logic got;
        logic strobeSeen;
        logic [31:0] sAddr;
        logic [3:0]  sSel;
        logic [31:0] sWdata;
        logic sRen;
        logic sWen;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        mif.i_req     = v.fetch;
        mif.i_addr    = v.fetch ? v.addr : 32'h0;
        mif.d_ren     = v.ren;
        mif.d_wen     = v.wen;
        mif.d_addr    = v.addr;
        mif.d_size    = v.size;
        mif.d_wdata   = v.wdata;
        mif.bus_rdata = v.rdata;
        mif.bus_busy  = (v.busy > 0);
        #1;
        chk({tag, " stall_req"}, {31'b0, mif.stall}, 32'h1);
        cyc = 0;
        got = 1'b0;
        strobeSeen = 1'b0;
        sAddr = '0; sSel = '0; sWdata = '0; sRen = 1'b0; sWen = 1'b0;
        while (!got && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) begin
                sAddr = mif.bus_addr; sSel = mif.bus_sel; sWdata = mif.bus_wdata;
                sRen = mif.bus_ren; sWen = mif.bus_wen;
            end
            if (mif.bus_ren || mif.bus_wen) strobeSeen = 1'b1;
            mif.bus_busy = (cyc <= v.busy);
            got = v.fetch ? mif.instr_valid : mif.d_done;
        end
        chk({tag, " latency"}, cyc, v.mis ? 1 : 2 + v.busy);
        chk({tag, " misalign"}, {31'b0, mif.misalign}, {31'b0, v.mis});
        chk({tag, " stall_done"}, {31'b0, mif.stall}, 32'h0);
        chk({tag, " strobes_drop"}, {30'b0, mif.bus_ren, mif.bus_wen}, 32'h0);
        if (v.mis) begin
            chk({tag, " no_strobe"}, {31'b0, strobeSeen}, 32'h0);
        end else begin
            chk({tag, " addr"}, sAddr, v.eAddr);
            chk({tag, " sel"}, {28'b0, sSel}, {28'b0, v.eSel});
            chk({tag, " ren"}, {31'b0, sRen}, {31'b0, ~v.wen});
            chk({tag, " wen"}, {31'b0, sWen}, {31'b0, v.wen});
            if (v.wen) chk({tag, " wdata"}, sWdata, v.eWdata);
            if (v.fetch) modelInstr = v.eData;
            else if (!v.wen) modelLoad = v.eData;
        end
        chk({tag, " instr_out"}, mif.instr_out, modelInstr);
        chk({tag, " memload"}, mif.memload, modelLoad);
        idleInputs();
        @(posedge clk);
        #1;
        chk({tag, " pulse_clear"}, {30'b0, mif.instr_valid, mif.d_done}, 32'h0);
    endtask

    initial begin
        int cyc;
        logic sawDone;
        nCmp = 0;
        nFail = 0;
        modelInstr = '0;
        modelLoad  = '0;
        idleInputs();
        mif.i_addr = '0; mif.d_addr = '0; mif.d_size = '0; mif.d_wdata = '0; mif.bus_rdata = '0;

        //           f  r  w  addr          size   wdata          rdata          busy mis eAddr         eSel     eWdata         eData
        vecs[0] = '{1, 0, 0, 32'h0000_0100, 2'b10, 32'h0,         32'h0050_0093, 0,   0, 32'h0000_0100, 4'b1111, 32'h0,         32'h0050_0093};
        vecs[1] = '{0, 0, 1, 32'h0000_0303, 2'b00, 32'h0000_00AB, 32'h0,         3,   0, 32'h0000_0300, 4'b1000, 32'hAB00_0000, 32'h0};
        vecs[2] = '{0, 1, 0, 32'h0000_0402, 2'b01, 32'h0,         32'hBEEF_1234, 0,   0, 32'h0000_0400, 4'b1100, 32'h0,         32'h0000_BEEF};
        vecs[3] = '{0, 1, 0, 32'h0000_0401, 2'b00, 32'h0,         32'h1122_3344, 1,   0, 32'h0000_0400, 4'b0010, 32'h0,         32'h0011_2233};
        vecs[4] = '{0, 0, 1, 32'h0000_0208, 2'b10, 32'hDEAD_BEEF, 32'h0,         0,   0, 32'h0000_0208, 4'b1111, 32'hDEAD_BEEF, 32'h0};
        vecs[5] = '{0, 0, 1, 32'h0000_0600, 2'b01, 32'h0000_CAFE, 32'h0,         2,   0, 32'h0000_0600, 4'b0011, 32'h0000_CAFE, 32'h0};
        vecs[6] = '{0, 1, 0, 32'h0000_0501, 2'b10, 32'h0,         32'hFFFF_FFFF, 0,   1, 32'h0,         4'b0000, 32'h0,         32'h0};
        vecs[7] = '{0, 0, 1, 32'h0000_0703, 2'b01, 32'h1234_5678, 32'h0,         0,   1, 32'h0,         4'b0000, 32'h0,         32'h0};
        vecs[8] = '{0, 1, 0, 32'h0000_080C, 2'b11, 32'h0,         32'hA5A5_5A5A, 1,   0, 32'h0000_080C, 4'b1111, 32'h0,         32'hA5A5_5A5A};
        vecs[9] = '{0, 1, 1, 32'h0000_00A1, 2'b00, 32'h0000_0055, 32'h0,         0,   0, 32'h0000_00A0, 4'b0010, 32'h0000_5500, 32'h0};

        nRst = 1'b0;
        #12;
        chk("rst bus_addr", mif.bus_addr, 32'h0);
        chk("rst strobes", {30'b0, mif.bus_ren, mif.bus_wen}, 32'h0);
        chk("rst outs", mif.instr_out | mif.memload | mif.bus_wdata, 32'h0);
        chk("rst pulses", {28'b0, mif.instr_valid, mif.d_done, mif.misalign, mif.bus_err}, 32'h0);
        @(negedge clk);
        nRst = 1'b1;

        for (int i = 0; i < 10; i++) runVec(i, vecs[i]);

        // Simultaneous fetch and word load: data wins, fetch follows after DONE.
        @(negedge clk);
        mif.i_req = 1'b1; mif.i_addr = 32'h100;
        mif.d_ren = 1'b1; mif.d_addr = 32'h204; mif.d_size = 2'b10;
        mif.bus_rdata = 32'h0BAD_F00D;
        @(posedge clk); #1;
        chk("simul data_first addr", mif.bus_addr, 32'h204);
        chk("simul data_first ren", {31'b0, mif.bus_ren}, 32'h1);
        @(posedge clk); #1;
        chk("simul d_done", {30'b0, mif.d_done, mif.instr_valid}, 32'h2);
        chk("simul memload", mif.memload, 32'h0BAD_F00D);
        modelLoad = 32'h0BAD_F00D;
        mif.d_ren = 1'b0;
        mif.bus_rdata = 32'h0050_0093;
        @(posedge clk); #1;
        chk("simul idle gap", {31'b0, mif.bus_ren}, 32'h0);
        @(posedge clk); #1;
        chk("simul fetch addr", mif.bus_addr, 32'h100);
        chk("simul fetch ren", {31'b0, mif.bus_ren}, 32'h1);
        @(posedge clk); #1;
        chk("simul instr_valid", {31'b0, mif.instr_valid}, 32'h1);
        chk("simul instr_out", mif.instr_out, 32'h0050_0093);
        modelInstr = 32'h0050_0093;
        idleInputs();
        @(posedge clk); #1;

        // Bus held busy: abort after 64 busy cycles, or wait indefinitely without the timeout.
        @(negedge clk);
        mif.d_ren = 1'b1; mif.d_addr = 32'h440; mif.d_size = 2'b10;
        mif.bus_rdata = 32'hFFFF_0000; mif.bus_busy = 1'b1;
        cyc = 0;
        sawDone = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
        while (!sawDone && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            sawDone = mif.d_done;
        end
        chk("timeout latency", cyc, 65);
        chk("timeout bus_err", {31'b0, mif.bus_err}, 32'h1);
        chk("timeout memload kept", mif.memload, modelLoad);
        mif.d_ren = 1'b0; mif.bus_busy = 1'b0;
        @(posedge clk); #1;
        chk("timeout pulse clear", {30'b0, mif.bus_err, mif.d_done}, 32'h0);
`else
        while (!sawDone && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            sawDone = mif.d_done | mif.bus_err;
        end
        chk("busy wait no done", {31'b0, sawDone}, 32'h0);
        chk("busy wait stall", {31'b0, mif.stall}, 32'h1);
        mif.bus_busy = 1'b0;
        @(posedge clk); #1;
        chk("busy release d_done", {31'b0, mif.d_done}, 32'h1);
        chk("busy release memload", mif.memload, 32'hFFFF_0000);
        chk("bus_err tied low", {31'b0, mif.bus_err}, 32'h0);
        modelLoad = 32'hFFFF_0000;
        mif.d_ren = 1'b0;
        @(posedge clk); #1;
`endif

        // Reset in the middle of a data access: everything clears, no completion.
        @(negedge clk);
        mif.d_ren = 1'b1; mif.d_addr = 32'h404; mif.d_size = 2'b10; mif.bus_busy = 1'b1;
        @(posedge clk); #1;
        chk("midrst ren before", {31'b0, mif.bus_ren}, 32'h1);
        @(posedge clk); #3;
        nRst = 1'b0;
        #1;
        chk("midrst strobes", {30'b0, mif.bus_ren, mif.bus_wen}, 32'h0);
        chk("midrst addr_sel", mif.bus_addr | {28'b0, mif.bus_sel}, 32'h0);
        chk("midrst data", mif.memload | mif.instr_out, 32'h0);
        idleInputs();
        @(negedge clk);
        nRst = 1'b1;
        sawDone = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (mif.d_done || mif.instr_valid) sawDone = 1'b1;
        end
        chk("midrst no done", {31'b0, sawDone}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences the single shared memory bus between instruction fetch and data load/store requests in the RV32I core.
- Generates byte enables and performs store lane alignment.
- Returns load data right-aligned so that write-back can sign- or zero-extend it.
- Stalls the pipeline while any access is outstanding.

Parameters:
- TIMEOUT_CYC, 64: number of consecutive bus_busy cycles before an access is aborted. Used only when the optional feature is enabled.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- nRst  in  1  asynchronous active-low reset.
- i_req  in  1  fetch request; level, held until instr_valid.
- i_addr  in  32  fetch address; word-aligned.
- d_ren  in  1  load request; level, held until d_done.
- d_wen  in  1  store request; level, held until d_done.
- d_addr  in  32  load/store byte address.
- d_size  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
- d_wdata  in  32  store data, right-aligned.
- bus_busy  in  1  bus still working on the current access.
- bus_rdata  in  32  bus read word.
- bus_ren  out  1  bus read strobe.
- bus_wen  out  1  bus write strobe.
- bus_addr  out  32  word address: request address with bits [1:0] forced to 0.
- bus_sel  out  4  byte enables.
- bus_wdata  out  32  lane-shifted store data.
- instr_out  out  32  fetched instruction.
- instr_valid  out  1  one-cycle pulse: fetch complete.
- memload  out  32  load data, right-aligned, upper bits unmasked.
- d_done  out  1  one-cycle pulse: load/store complete or rejected.
- misalign  out  1  one-cycle pulse together with d_done when an access is rejected.
- bus_err  out  1  one-cycle timeout abort pulse.
- stall  out  1  high while any request is pending and not yet completed.

Behaviour:
- Reset: nRst low forces the following immediately and asynchronously:
  - state = IDLE;
  - every registered output = 0 (instr_out, memload, bus_addr, bus_sel, bus_wdata);
  - every strobe and pulse = 0.
  - Reset mid-access abandons the access; no completion pulse is ever issued for it.
- States:
  - IDLE:
    - If d_ren|d_wen and the access is misaligned: go to DONE; pulse d_done and misalign; no bus activity.
    - Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
    - Else if d_ren|d_wen: go to DATA.
    - Else if i_req: go to FETCH.
    - Data has priority over fetch, because the data request belongs to an older instruction.
    - d_ren and d_wen both high is treated as a store.
  - FETCH / DATA:
    - Strobe (bus_ren, or bus_wen for stores) plus bus_addr/bus_sel/bus_wdata are registered on entry and held constant for the whole state.
    - The access completes on the first edge after entry at which bus_busy=0; minimum latency is 2 cycles from the request to the done pulse.
    - On completion: strobes drop; go to DONE.
    - FETCH completion: instr_out <= bus_rdata; instr_valid pulses.
    - DATA load completion: memload <= bus_rdata >> (8*d_addr[1:0]); d_done pulses.
    - DATA store completion: d_done pulses.
  - DONE:
    - Held for exactly one cycle, so requesters can drop or update their requests; always returns to IDLE.
    - A new request can be accepted on the following cycle.
- Byte enables:
  - byte: 0001 << addr[1:0].
  - half: 0011 when addr[1]=0, 1100 when addr[1]=1.
  - word: 1111.
  - fetch: 1111.
- bus_wdata = d_wdata << (8*addr[1:0]).
- stall = (i_req|d_ren|d_wen) & ~(instr_valid|d_done). stall is combinational from the registered pulses and is low in the cycle a pulse is high.
- instr_out and memload hold their values until the next completion of their own kind.

Optional Feature:
- Macro: MEM_ACCESS_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to FETCH/DATA and increments each cycle bus_busy=1.
  - On reaching TIMEOUT_CYC: drop strobes, pulse bus_err plus the matching instr_valid/d_done, leave instr_out/memload unchanged, go to DONE.
- Undefined: no counter; the block waits on bus_busy indefinitely; bus_err is tied to 0.

Test Plan:
- Fetch with bus_busy low immediately:
  - i_req=1, i_addr=0x100, bus_rdata=0x00500093.
  - Expected: bus_ren=1 with sel 1111 for 1 cycle; instr_out=0x00500093; instr_valid pulses 2 cycles after the request; stall high for exactly 2 cycles.
- Simultaneous requests:
  - i_req and d_ren together, d_addr=0x204, word.
  - Expected: DATA is served first (bus_addr=0x204); d_done; DONE; then FETCH starts 1 cycle later.
- Byte store:
  - d_wen, d_addr=0x303, byte, d_wdata=0x000000AB.
  - Expected: bus_addr=0x300, bus_sel=1000, bus_wdata=0xAB000000; bus_busy high 3 cycles; d_done after 5 cycles.
- Half load:
  - d_ren, d_addr=0x402, half, bus_rdata=0xBEEF1234.
  - Expected: bus_sel=1100; memload=0x0000BEEF.
- Misaligned accesses:
  - Word at 0x501: d_done and misalign pulse 1 cycle later; bus_ren/bus_wen never asserted.
  - nRst pulsed low mid-DATA: all outputs 0 immediately; no d_done.
- With MEM_ACCESS_TIMEOUT_EN:
  - bus_busy held high with TIMEOUT_CYC=64.
  - Expected: bus_err and d_done pulse once after 64 busy cycles; FSM returns to IDLE.
